// File: rtl/spram_arb2_if.sv
// Bus bundle between the two requesters, the arbiter and the shared SPRAM.
interface spram_arb2_if #(
    parameter int unsigned AW = 15
) ();
    // port 0: Forth core data bus
    logic          req0;
    logic          lock0;
    logic          we0;
    logic [AW-1:0] ai0;
    logic [31:0]   vi0;
    logic [3:0]    bmsk0;
    logic          gnt0;
    logic          rvalid0;
    logic [31:0]   rdata0;

    // port 1: debug/loader bus
    logic          req1;
    logic          lock1;
    logic          we1;
    logic [AW-1:0] ai1;
    logic [31:0]   vi1;
    logic [3:0]    bmsk1;
    logic          gnt1;
    logic          rvalid1;
    logic [31:0]   rdata1;

    // memory side
    logic          m_we;
    logic [AW-1:0] m_ai;
    logic [31:0]   m_vi;
    logic [3:0]    m_bmsk;
    logic [31:0]   m_vo;

    // arbiter view
    modport slave (
        input  req0, lock0, we0, ai0, vi0, bmsk0,
        output gnt0, rvalid0, rdata0,
        input  req1, lock1, we1, ai1, vi1, bmsk1,
        output gnt1, rvalid1, rdata1,
        output m_we, m_ai, m_vi, m_bmsk,
        input  m_vo
    );

    // requester + memory view
    modport master (
        output req0, lock0, we0, ai0, vi0, bmsk0,
        input  gnt0, rvalid0, rdata0,
        output req1, lock1, we1, ai1, vi1, bmsk1,
        input  gnt1, rvalid1, rdata1,
        input  m_we, m_ai, m_vi, m_bmsk,
        output m_vo
    );
endinterface

// File: rtl/spram_arb2.sv
// Two-port round-robin arbiter with bounded burst lock in front of one SPRAM.
module spram_arb2 #(
    parameter int unsigned BURST_MAX = 8,
    parameter int unsigned AW        = 15
) (
    input  logic         clk,
    input  logic         rst,
    spram_arb2_if.slave  io_bus
);
    localparam int unsigned    BW   = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0]  BMAX = BW'(BURST_MAX);

    logic          r_prio;     // port preferred when both request
    logic          r_owner;    // last granted port
    logic          r_gl;       // some port was granted last cycle
    logic [BW-1:0] r_bcnt;     // consecutive locked grants to owner
    logic          r_rpend;    // read issued last cycle
    logic          r_rsel;     // port that issued that read

    logic          w_own_req;
    logic          w_own_lock;
    logic          w_oth_req;
    logic          w_cont;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gnt_any;
    logic          w_gsel;
    logic          w_glock;
    logic          w_gwe;
    logic [BW-1:0] w_bcnt_nxt;
    logic          w_m_we;
    logic [AW-1:0] w_m_ai;
    logic [31:0]   w_m_vi;
    logic [3:0]    w_m_bmsk;

    // Grant decision: lock continuation, then lone requester, then round-robin.
    always_comb begin
        w_own_req  = r_owner ? io_bus.req1  : io_bus.req0;
        w_own_lock = r_owner ? io_bus.lock1 : io_bus.lock0;
        w_oth_req  = r_owner ? io_bus.req0  : io_bus.req1;
        w_cont     = r_gl && w_own_req && w_own_lock && ((r_bcnt < BMAX) || !w_oth_req);
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        if (!rst) begin
            if (w_cont) begin
                w_gnt0 = !r_owner;
                w_gnt1 = r_owner;
            end else if (io_bus.req0 && !io_bus.req1) begin
                w_gnt0 = 1'b1;
            end else if (io_bus.req1 && !io_bus.req0) begin
                w_gnt1 = 1'b1;
            end else if (io_bus.req0 && io_bus.req1) begin
                w_gnt0 = !r_prio;
                w_gnt1 = r_prio;
            end
        end
        w_gnt_any = w_gnt0 || w_gnt1;
        w_gsel    = w_gnt1;
        w_glock   = w_gsel ? io_bus.lock1 : io_bus.lock0;
        w_gwe     = w_gsel ? io_bus.we1   : io_bus.we0;
    end

    // Burst length bookkeeping; a locked grant that follows the owner's own grant extends the run.
    always_comb begin
        w_bcnt_nxt = '0;
        if (w_gnt_any) begin
            if (w_glock && r_gl && (w_gsel == r_owner)) begin
                w_bcnt_nxt = (r_bcnt == BMAX) ? BMAX : BW'(r_bcnt + 1'b1);
            end else begin
                w_bcnt_nxt = w_glock ? BW'(1) : '0;
            end
        end
    end

    // Memory mux; idle cycles park the address/data on port 0.
    always_comb begin
        w_m_we   = 1'b0;
        w_m_bmsk = 4'h0;
        w_m_ai   = io_bus.ai0;
        w_m_vi   = io_bus.vi0;
        if (w_gnt0) begin
            w_m_we   = io_bus.we0;
            w_m_bmsk = io_bus.bmsk0;
        end else if (w_gnt1) begin
            w_m_we   = io_bus.we1;
            w_m_ai   = io_bus.ai1;
            w_m_vi   = io_bus.vi1;
            w_m_bmsk = io_bus.bmsk1;
        end
    end

    assign io_bus.gnt0   = w_gnt0;
    assign io_bus.gnt1   = w_gnt1;
    assign io_bus.m_we   = w_m_we;
    assign io_bus.m_ai   = w_m_ai;
    assign io_bus.m_vi   = w_m_vi;
    assign io_bus.m_bmsk = w_m_bmsk;

    // Read return steering; a read in flight across reset is dropped.
    assign io_bus.rvalid0 = r_rpend && !r_rsel && !rst;
    assign io_bus.rvalid1 = r_rpend &&  r_rsel && !rst;
    assign io_bus.rdata0  = io_bus.m_vo;
    assign io_bus.rdata1  = io_bus.m_vo;

    // Arbiter state and read tag update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_gl    <= 1'b0;
            r_bcnt  <= '0;
            r_rpend <= 1'b0;
            r_rsel  <= 1'b0;
        end else begin
            r_gl    <= w_gnt_any;
            r_bcnt  <= w_bcnt_nxt;
            r_rpend <= w_gnt_any && !w_gwe;
            r_rsel  <= w_gsel;
            if (w_gnt_any) begin
                r_prio  <= ~w_gsel;
                r_owner <= w_gsel;
            end
        end
    end
endmodule

// File: tb/tb_spram_arb2.sv
// Self-checking bench for spram_arb2: directed scenarios plus random traffic against a reference model.
module tb_spram_arb2;
    localparam int unsigned AW        = 15;
    localparam int unsigned BURST_MAX = 8;
    localparam int unsigned DEPTH     = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spram_arb2_if #(.AW(AW)) bus ();
    spram_arb2 #(.BURST_MAX(BURST_MAX), .AW(AW)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    logic [31:0] sram    [DEPTH];   // memory attached to the arbiter
    logic [31:0] ref_mem [DEPTH];   // expected memory contents

    // requester stimulus
    logic          p_req  [2];
    logic          p_lock [2];
    logic          p_we   [2];
    logic [AW-1:0] p_ai   [2];
    logic [31:0]   p_vi   [2];
    logic [3:0]    p_bm   [2];

    // reference model state
    int          m_last;   // port granted in the previous cycle, -1 if none
    int          m_own;    // most recently granted port
    int          m_pref;   // port that wins a tie
    int          m_run;    // length of the current locked run
    int          exp_rv;   // port expecting read data this cycle, -1 if none
    logic [31:0] exp_rd;

    // observations
    int          last_g;
    int          g_hist[$];
    logic        o_rv [2];
    logic [31:0] o_rd [2];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [31:0] init_val(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // SPRAM: byte-masked write, registered read
    always @(posedge clk) begin
        if (bus.m_we) begin
            for (int k = 0; k < 4; k++)
                if (bus.m_bmsk[k]) sram[bus.m_ai][8*k +: 8] <= bus.m_vi[8*k +: 8];
        end
        bus.m_vo <= sram[bus.m_ai];
    end

    function automatic int exp_grant();
        int oth;
        if (rst) return -1;
        oth = 1 - m_own;
        if (m_last == m_own && p_req[m_own] && p_lock[m_own] &&
            (m_run < int'(BURST_MAX) || !p_req[oth])) return m_own;
        if (p_req[0] && p_req[1]) return m_pref;
        if (p_req[0]) return 0;
        if (p_req[1]) return 1;
        return -1;
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        for (int k = 0; k < 4; k++)
            if (m[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic set_port(input int p, input logic rq, input logic lk, input logic we,
                            input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        p_req[p] = rq; p_lock[p] = lk; p_we[p] = we; p_ai[p] = a; p_vi[p] = d; p_bm[p] = m;
    endtask

    task automatic new_txn(input int p);
        set_port(p, ($urandom % 4) != 0, ($urandom % 3) == 0, 1'($urandom % 2),
                 AW'($urandom % 64), $urandom, 4'($urandom));
    endtask

    // One clock: drive, check at the falling edge, advance the model.
    task automatic run_cycle();
        int g;
        int rv;
        bus.req0 = p_req[0]; bus.lock0 = p_lock[0]; bus.we0 = p_we[0];
        bus.ai0  = p_ai[0];  bus.vi0   = p_vi[0];   bus.bmsk0 = p_bm[0];
        bus.req1 = p_req[1]; bus.lock1 = p_lock[1]; bus.we1 = p_we[1];
        bus.ai1  = p_ai[1];  bus.vi1   = p_vi[1];   bus.bmsk1 = p_bm[1];
        @(negedge clk);
        g  = exp_grant();
        rv = rst ? -1 : exp_rv;
        check("gnt0",    32'(bus.gnt0),    32'(g == 0));
        check("gnt1",    32'(bus.gnt1),    32'(g == 1));
        check("rvalid0", 32'(bus.rvalid0), 32'(rv == 0));
        check("rvalid1", 32'(bus.rvalid1), 32'(rv == 1));
        if (rv == 0) check("rdata0", bus.rdata0, exp_rd);
        if (rv == 1) check("rdata1", bus.rdata1, exp_rd);
        check("m_we",   32'(bus.m_we),   (g >= 0) ? 32'(p_we[g]) : 32'd0);
        check("m_bmsk", 32'(bus.m_bmsk), (g >= 0) ? 32'(p_bm[g]) : 32'd0);
        if (g >= 0) begin
            check("m_ai", 32'(bus.m_ai), 32'(p_ai[g]));
            check("m_vi", bus.m_vi, p_vi[g]);
        end
        o_rv[0] = bus.rvalid0; o_rv[1] = bus.rvalid1;
        o_rd[0] = bus.rdata0;  o_rd[1] = bus.rdata1;
        last_g = g;
        g_hist.push_back(g);

        exp_rv = -1;
        if (rst) begin
            m_pref = 0; m_own = 0; m_run = 0; m_last = -1;
        end else if (g >= 0) begin
            if (p_lock[g] && g == m_last) m_run = (m_run < int'(BURST_MAX)) ? m_run + 1 : int'(BURST_MAX);
            else                          m_run = p_lock[g] ? 1 : 0;
            m_pref = 1 - g; m_own = g; m_last = g;
            if (p_we[g]) ref_write(p_ai[g], p_vi[g], p_bm[g]);
            else begin
                exp_rv = g;
                exp_rd = ref_mem[p_ai[g]];
            end
        end else begin
            m_last = -1; m_run = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        idle_ports();
        rst = 1'b1;
        run_cycle();
        run_cycle();
        rst = 1'b0;
        g_hist.delete();
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            sram[i]    = init_val(i);
            ref_mem[i] = init_val(i);
        end
        m_last = -1; m_own = 0; m_pref = 0; m_run = 0; exp_rv = -1; exp_rd = '0; last_g = -1;
        idle_ports();
        bus.m_vo = '0;
        #1;

        // write on port 0, read back on port 1
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b1, AW'(16), 32'hDEADBEEF, 4'hF);
        run_cycle();
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, AW'(16), '0, '0);
        run_cycle();
        idle_ports();
        run_cycle();
        check("t1_first_gnt",  32'(g_hist[0]), 32'd0);
        check("t1_second_gnt", 32'(g_hist[1]), 32'd1);
        check("t1_rvalid1",    32'(o_rv[1]),   32'd1);
        check("t1_rvalid0",    32'(o_rv[0]),   32'd0);
        check("t1_rdata1",     o_rd[1],        32'hDEADBEEF);

        // continuous reads from both ports alternate
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, AW'(256), '0, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, AW'(512), '0, '0);
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            if (last_g >= 0) p_ai[last_g] = AW'(p_ai[last_g] + 1);
        end
        idle_ports();
        run_cycle();
        for (int c = 0; c < 8; c++) check("t2_alternate", 32'(g_hist[c]), 32'(c % 2));

        // port 1 locked burst, port 0 arrives at cycle 3
        do_reset();
        for (int c = 0; c < 20; c++) begin
            set_port(1, 1'b1, 1'b1, 1'b0, AW'(1024 + c), '0, '0);
            if (c == 3) set_port(0, 1'b1, 1'b0, 1'b0, AW'(768), '0, '0);
            run_cycle();
            if (last_g == 0) p_req[0] = 1'b0;
        end
        idle_ports();
        run_cycle();
        for (int c = 0; c < 8; c++) check("t3_burst", 32'(g_hist[c]), 32'd1);
        check("t3_release", 32'(g_hist[8]), 32'd0);
        check("t3_resume",  32'(g_hist[9]), 32'd1);

        // lone locked port 0 is never interrupted
        do_reset();
        for (int c = 0; c < 20; c++) begin
            set_port(0, 1'b1, 1'b1, 1'b0, AW'(2048 + c), '0, '0);
            run_cycle();
        end
        for (int c = 0; c < 20; c++) check("t4_lone_lock", 32'(g_hist[c]), 32'd0);
        check("t4_bcnt_sat", 32'(dut.r_bcnt), 32'(BURST_MAX));
        idle_ports();
        run_cycle();

        // byte-masked write merge
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b1, AW'(32), 32'h11223344, 4'hF);
        run_cycle();
        set_port(0, 1'b1, 1'b0, 1'b1, AW'(32), 32'h00AB0000, 4'b0100);
        run_cycle();
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, AW'(32), '0, '0);
        run_cycle();
        idle_ports();
        run_cycle();
        check("t5_rvalid1", 32'(o_rv[1]), 32'd1);
        check("t5_merge",   o_rd[1],      32'h11AB3344);

        // reset drops an in-flight read and restores port-0 preference
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, AW'(48), '0, '0);
        run_cycle();
        idle_ports();
        rst = 1'b1;
        run_cycle();
        check("t6_dropped_read", 32'(o_rv[0]), 32'd0);
        rst = 1'b0;
        set_port(0, 1'b1, 1'b0, 1'b0, AW'(49), '0, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, AW'(50), '0, '0);
        run_cycle();
        check("t6_port0_first", 32'(last_g), 32'd0);
        idle_ports();
        run_cycle();

        // random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++)
                if (!p_req[p] || last_g == p) new_txn(p);
            rst = (($urandom % 200) == 0);
            run_cycle();
        end
        rst = 1'b0;
        idle_ports();
        run_cycle();
        run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
